// File: rtl/w_fetch.sv
// Read-side initiator for the single-port weight RAM: issues a burst of reads
// under credit control and streams the words out through a 2-entry FIFO.
module w_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 10
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  start,
  input  logic [ADDR_SIZE-1:0]  base_addr,
  input  logic [ADDR_SIZE:0]    len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_SIZE-1:0]  ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_SIZE:0] ONE = {{ADDR_SIZE{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [ADDR_SIZE-1:0]  base_q, base_d;
  logic [ADDR_SIZE:0]    len_q, len_d;
  logic [ADDR_SIZE:0]    issue_q, issue_d;
  logic [ADDR_SIZE:0]    pop_q, pop_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
  logic [DATA_WIDTH-1:0] slot1_q, slot1_d;

  logic       pop_s;
  logic       push_s;
  logic [2:0] occ_s;

  assign ram_wea   = 1'b0;
  assign ram_dina  = {DATA_WIDTH{1'b0}};
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign m_valid   = (count_q != 2'd0);
  assign m_data    = rd_ptr_q ? slot1_q : slot0_q;
  assign m_last    = m_valid && ((pop_q + ONE) == len_q);
  assign ram_addra = base_q + issue_q[ADDR_SIZE-1:0];

  // Credit: words held plus the read in flight, less the word leaving now, must leave room for one more.
  always_comb begin
    pop_s   = m_valid && m_ready;
    push_s  = inflight_q;
    occ_s   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    ram_ena = (state_q == READ) && (issue_q != len_q) && (occ_s <= 3'd1);
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issue_d    = ram_ena ? issue_q + ONE : issue_q;
    pop_d      = pop_s ? pop_q + ONE : pop_q;
    inflight_d = ram_ena;
    rd_ptr_d   = pop_s ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d   = push_s ? ~wr_ptr_q : wr_ptr_q;
    slot0_d    = slot0_q;
    slot1_d    = slot1_q;
    count_d    = count_q + {1'b0, push_s} - {1'b0, pop_s};

    if (push_s) begin
      if (wr_ptr_q) begin
        slot1_d = ram_douta;
      end else begin
        slot0_d = ram_douta;
      end
    end else begin
      slot0_d = slot0_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != {(ADDR_SIZE+1){1'b0}}) begin
            base_d  = base_addr;
            len_d   = len;
            issue_d = {(ADDR_SIZE+1){1'b0}};
            pop_d   = {(ADDR_SIZE+1){1'b0}};
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (ram_ena && ((issue_q + ONE) == len_q)) begin
          state_d = DRAIN;
        end else begin
          state_d = READ;
        end
      end
      // The last issue always precedes the last pop, so the final word leaves from DRAIN.
      DRAIN: begin
        if (pop_s && ((pop_q + ONE) == len_q)) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q    <= IDLE;
      base_q     <= {ADDR_SIZE{1'b0}};
      len_q      <= {(ADDR_SIZE+1){1'b0}};
      issue_q    <= {(ADDR_SIZE+1){1'b0}};
      pop_q      <= {(ADDR_SIZE+1){1'b0}};
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      slot0_q    <= {DATA_WIDTH{1'b0}};
      slot1_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      pop_q      <= pop_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
    end
  end

endmodule
